bram_add_seq: RTL

- Sequencer that drives the native BRAM ports (clk/ena/wea/addra/dina/douta) as their initiator.
- Streams N words from operand BRAM 1 and operand BRAM 2, adds each pair, and writes the sum to result BRAM 3 at the same address.
- Sits between the top-level control and the three bram wrapper instances; all three memories share clk.

---
 rtl/bram_add_pkg.sv | 14 +
 rtl/bram_add_dly.sv | 37 +++
 rtl/bram_add_seq.sv | 128 ++++++++++++
 3 files changed

// File: rtl/bram_add_pkg.sv
// Shared types and default geometry for the BRAM add sequencer.
package bram_add_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/bram_add_dly.sv
// Shift register that carries a read's {valid, address} tag for DEPTH cycles
// so it lines up with the BRAM read data.
module bram_add_dly #(
   parameter int DEPTH = 1,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [AW-1:0] in_addr,
   output logic          out_valid,
   output logic [AW-1:0] out_addr,
   output logic          pending
);

   logic [DEPTH-1:0] vld;
   logic [AW-1:0]    adr [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         for (int i = 0; i < DEPTH; i++) adr[i] <= '0;
      end else begin
         vld[0] <= in_valid;
         adr[0] <= in_addr;
         for (int i = 1; i < DEPTH; i++) begin
            vld[i] <= vld[i-1];
            adr[i] <= adr[i-1];
         end
      end
   end

   assign out_valid = vld[DEPTH-1];
   assign out_addr  = adr[DEPTH-1];
   assign pending   = |vld;

endmodule

// File: rtl/bram_add_seq.sv
// Streams N word pairs out of BRAM 1 and BRAM 2, adds them and writes the
// sums into BRAM 3 at the same address; ovf records any carry in the run.
module bram_add_seq
   import bram_add_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W:0]   len,
   output logic              ena1,
   output logic              wea1,
   output logic [ADDR_W-1:0] addra1,
   input  logic [DATA_W-1:0] douta1,
   output logic              ena2,
   output logic              wea2,
   output logic [ADDR_W-1:0] addra2,
   input  logic [DATA_W-1:0] douta2,
   output logic              ena3,
   output logic              wea3,
   output logic [ADDR_W-1:0] addra3,
   output logic [DATA_W-1:0] dina3,
   output logic              busy,
   output logic              done,
   output logic              ovf,
   output logic [1:0]        dbg_state
);

   // Handshake: start is a one-cycle request honoured only in IDLE (len is
   // captured on that edge); busy covers RUN and DRAIN; done pulses for one
   // cycle after the last sum has been presented to BRAM 3.

   state_t            state, state_nxt;
   logic [ADDR_W:0]   len_q;
   logic [ADDR_W:0]   rd_idx;
   logic              rd_en;
   logic              accept;
   logic              dly_valid;
   logic [ADDR_W-1:0] dly_addr;
   logic              dly_pending;
   logic [DATA_W:0]   sum;
   logic              ena3_q;
   logic [ADDR_W-1:0] addra3_q;
   logic [DATA_W-1:0] dina3_q;
   logic              ovf_q;

   assign accept = (state == IDLE) && start;
   assign rd_en  = (state == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         len_q  <= '0;
         rd_idx <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            len_q  <= len;
            rd_idx <= '0;
         end else if (rd_en) begin
            rd_idx <= rd_idx + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (len != '0) ? RUN : DONE;
         RUN:     if (rd_idx + 1'b1 == len_q) state_nxt = DRAIN;
         // The last write is on the port once ena3 is up and no tag remains.
         DRAIN:   if (ena3_q && !dly_pending) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   bram_add_dly #(
      .DEPTH (RD_LAT),
      .AW    (ADDR_W)
   ) u_dly (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (rd_en),
      .in_addr   (rd_idx[ADDR_W-1:0]),
      .out_valid (dly_valid),
      .out_addr  (dly_addr),
      .pending   (dly_pending)
   );

   assign sum = {1'b0, douta1} + {1'b0, douta2};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ena3_q   <= 1'b0;
         addra3_q <= '0;
         dina3_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         ena3_q <= dly_valid;
         if (dly_valid) begin
            addra3_q <= dly_addr;
            dina3_q  <= sum[DATA_W-1:0];
         end
         if (accept) ovf_q <= 1'b0;
         else if (dly_valid && sum[DATA_W]) ovf_q <= 1'b1;
      end
   end

   assign ena1      = rd_en;
   assign ena2      = rd_en;
   assign wea1      = 1'b0;
   assign wea2      = 1'b0;
   assign addra1    = rd_en ? rd_idx[ADDR_W-1:0] : '0;
   assign addra2    = rd_en ? rd_idx[ADDR_W-1:0] : '0;
   assign ena3      = ena3_q;
   assign wea3      = ena3_q;
   assign addra3    = addra3_q;
   assign dina3     = dina3_q;
   assign ovf       = ovf_q;
   assign busy      = (state == RUN) || (state == DRAIN);
   assign done      = (state == DONE);
   assign dbg_state = state;

endmodule
